udp_builder: RTL and testbench
==============================

// Module: udp_builder
// PURPOSE
//  Transmit-side counterpart of the UDP receive path: consumes raw payload frames (sof/eof-marked bytes) from a FWFT fifo_ctrl,
//  buffers each frame, computes lengths and checksums, then writes Ethernet+IPv4+UDP header (42 B) followed by the payload
//  into an output fifo_ctrl. Sits between the host-side payload FIFO and the line-side frame FIFO.
// PARAMETERS
//  DST_MAC      48'h00_11_22_33_44_55  Ethernet destination
//  SRC_MAC      48'h66_77_88_99_AA_BB  Ethernet source
//  SRC_IP       32'hC0A8_0001          IPv4 source (192.168.0.1)
//  DST_IP       32'hC0A8_0002          IPv4 destination (192.168.0.2)
//  SRC_PORT     16'h1234               UDP source port
//  DST_PORT     16'h5678               UDP destination port
//  TTL          8'h40                  IPv4 time-to-live
//  MAX_PAYLOAD  1472                   payload buffer depth in bytes; longer frames dropped
// PORTS
//  clock       in   1   single clock, all logic rising-edge
//  reset       in   1   synchronous, active-low reset
//  in_dout     in   8   payload byte at input FIFO head (valid while !in_empty)
//  in_sof      in   1   head byte is first of frame
//  in_eof      in   1   head byte is last of frame
//  in_empty    in   1   input FIFO empty
//  in_rd_en    out  1   pop input FIFO head this cycle
//  out_dout    out  8   frame byte to output FIFO
//  out_sof     out  1   marks first frame byte (DST_MAC[47:40])
//  out_eof     out  1   marks last payload byte
//  out_wr_en   out  1   write strobe; never high while out_full
//  out_full    in   1   output FIFO full
//  drop_count  out  16  saturating count of dropped oversize frames
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, all outputs 0, ip_id=0, drop_count=0, partial frame discarded; no write that cycle.
//  FSM: IDLE -> BUFFER -> FOLD1 -> FOLD2 -> HEADER -> PAYLOAD -> IDLE; BUFFER -> DROP -> IDLE on overflow.
//  in_rd_en = !in_empty && state in {IDLE,BUFFER,DROP}; byte consumed in cycle in_rd_en=1.
//  IDLE: bytes without in_sof popped and discarded. sof byte -> store at addr 0, len=1; if also eof -> FOLD1.
//  BUFFER: store byte, len++; eof -> FOLD1. New sof mid-frame: discard partial, restart at addr 0 with this byte.
//  Overflow: byte arriving when len==MAX_PAYLOAD -> DROP; pop until eof, drop_count++ (sat 16'hFFFF), return IDLE, nothing written.
//  Checksum: 17-bit-carry one's-complement accumulation of payload big-endian 16-bit words during BUFFER; odd length pads low byte 0.
//  FOLD1: add pseudo-header (SRC_IP,DST_IP,0x0011,udp_len) + UDP header (ports,udp_len), fold carries; udp_len=len+8.
//  FOLD2: IPv4 header checksum over {0x4500,len+28,ip_id,0x4000,TTL:0x11,0,IPs}; fold, invert. UDP csum inverted; 0x0000 -> 0xFFFF.
//  HEADER: 42 bytes, big-endian: DST_MAC, SRC_MAC, 08 00, 45 00, tot_len, ip_id, 40 00, TTL, 11, ip_csum, SRC_IP, DST_IP,
//          SRC_PORT, DST_PORT, udp_len, udp_csum. PAYLOAD: len bytes from buffer in order; eof on last; then ip_id++ (wraps 16 bits).
//  out_wr_en = !out_full && state in {HEADER,PAYLOAD}; byte index advances only on write; out_full stalls hold out_dout stable.
//  Latency: first header byte written 3 cycles after eof byte consumed (out_full=0). Throughput 1 B/cycle; input stalls during output.
//  Buffer read is synchronous: prefetch next payload byte so PAYLOAD sustains 1 B/cycle with no bubble at HEADER->PAYLOAD.
// TESTING
//  T1 payload 41 42 43 44 (sof on 41, eof on 44) -> 46 B: tot_len 0020, ip_csum B979, udp_len 000C, udp_csum 914F, eof on 44.
//  T2 single byte with sof+eof=1 (0x00) -> 43 B frame, udp_len 0009, tot_len 001D, odd-pad checksum, sof and eof on distinct bytes.
//  T3 frame of MAX_PAYLOAD+1 bytes then 4-byte frame -> only the 4-byte frame emitted, drop_count=1, ip_id of emitted frame 0000.
//  T4 random out_full toggling during T1 -> identical byte sequence, out_wr_en never high with out_full=1.
//  T5 sof at byte 3 of an unterminated frame, then 2 more bytes + eof -> one frame with udp_len 000B carrying the last 3 bytes.
//  T6 reset low mid-HEADER, release, resend T1 -> no further writes of old frame; new frame ip_id 0000, ip_csum B979.

Source files
------------

// File: rtl/udp_builder.sv
// UDP/IPv4/Ethernet transmit framer: buffers one payload frame, computes lengths and
// checksums while it arrives, then emits the 42-byte header followed by the payload.
module udp_builder #(
  parameter logic [47:0] DST_MAC     = 48'h00_11_22_33_44_55,
  parameter logic [47:0] SRC_MAC     = 48'h66_77_88_99_AA_BB,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT    = 16'h1234,
  parameter logic [15:0] DST_PORT    = 16'h5678,
  parameter logic [7:0]  TTL         = 8'h40,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_dout,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [7:0]  out_dout,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [15:0] drop_count
);
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BUFFER, S_FOLD1, S_FOLD2, S_HEADER, S_PAYLOAD, S_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d;
  logic [15:0]        csum_q, csum_d, ip_csum_q, ip_csum_d;
  logic [15:0]        ip_id_q, ip_id_d, drop_q, drop_d;
  logic [7:0]         mem [MAX_PAYLOAD];
  logic [7:0]         rd_data_q;
  logic               wr_mem;
  logic [LEN_W-1:0]   wr_addr;
  logic [15:0]        udp_len, tot_len;
  logic [31:0]        sum32;
  logic [335:0]       hdr;
  logic [8:0]         hdr_msb;

  function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [15:0] fold32(input logic [31:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {1'b0, s[31:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  assign udp_len    = 16'(len_q) + 16'd8;
  assign tot_len    = 16'(len_q) + 16'd28;
  assign drop_count = drop_q;
  assign in_rd_en   = reset && !in_empty &&
                      (state_q == S_IDLE || state_q == S_BUFFER || state_q == S_DROP);
  assign out_wr_en  = reset && !out_full && (state_q == S_HEADER || state_q == S_PAYLOAD);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    ip_csum_d = ip_csum_q;
    ip_id_d   = ip_id_q;
    drop_d    = drop_q;
    wr_mem    = 1'b0;
    wr_addr   = len_q;
    sum32     = 32'd0;
    case (state_q)
      S_IDLE, S_BUFFER: begin
        if (in_rd_en) begin
          if (in_sof) begin
            // sof always (re)starts a frame, discarding any partial one
            wr_mem  = 1'b1;
            wr_addr = '0;
            len_d   = LEN_W'(1);
            csum_d  = {in_dout, 8'h00};
            state_d = in_eof ? S_FOLD1 : S_BUFFER;
          end else if (state_q == S_BUFFER) begin
            if (len_q == LEN_W'(MAX_PAYLOAD)) begin
              drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
              state_d = in_eof ? S_IDLE : S_DROP;
            end else begin
              wr_mem  = 1'b1;
              len_d   = len_q + LEN_W'(1);
              csum_d  = add1c(csum_q, len_q[0] ? {8'h00, in_dout} : {in_dout, 8'h00});
              state_d = in_eof ? S_FOLD1 : S_BUFFER;
            end
          end
        end
      end
      S_FOLD1: begin
        sum32 = 32'(csum_q) + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) +
                32'(DST_IP[31:16]) + 32'(DST_IP[15:0]) + 32'h0011 +
                32'(udp_len) + 32'(SRC_PORT) + 32'(DST_PORT) + 32'(udp_len);
        csum_d  = fold32(sum32);
        idx_d   = '0;
        state_d = S_FOLD2;
      end
      S_FOLD2: begin
        sum32 = 32'h4500 + 32'(tot_len) + 32'(ip_id_q) + 32'h4000 + 32'({TTL, 8'h11}) +
                32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) +
                32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
        ip_csum_d = ~fold32(sum32);
        csum_d    = (csum_q == 16'hFFFF) ? 16'hFFFF : ~csum_q;
        state_d   = S_HEADER;
      end
      S_HEADER: begin
        if (out_wr_en) begin
          if (idx_q == LEN_W'(41)) begin
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      S_PAYLOAD: begin
        if (out_wr_en) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            idx_d   = '0;
            ip_id_d = ip_id_q + 16'd1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      S_DROP: begin
        if (in_rd_en && in_eof) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hdr = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, tot_len, ip_id_q, 16'h4000, TTL, 8'h11,
           ip_csum_q, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len, csum_q};
    hdr_msb  = 9'd335 - {idx_q[5:0], 3'b000};
    out_dout = 8'h00;
    out_sof  = 1'b0;
    out_eof  = 1'b0;
    if (reset && state_q == S_HEADER) begin
      out_dout = hdr[hdr_msb -: 8];
      out_sof  = (idx_q == '0);
    end else if (reset && state_q == S_PAYLOAD) begin
      out_dout = rd_data_q;
      out_eof  = (idx_q == len_q - LEN_W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      ip_csum_q <= '0;
      ip_id_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      ip_csum_q <= ip_csum_d;
      ip_id_q   <= ip_id_d;
      drop_q    <= drop_d;
    end
  end

  // Read address follows idx_d so the next payload byte is already waiting when it is needed.
  always_ff @(posedge clock) begin
    if (wr_mem) mem[wr_addr] <= in_dout;
    rd_data_q <= mem[idx_d];
  end
endmodule

// File: tb/tb_udp_builder.sv
// Self-checking bench for udp_builder: FWFT input FIFO driver, frame-level reference model,
// per-write comparison, plus literal pins of the model for the directed cases.
module tb_udp_builder;
  localparam int MAXP = 1472;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_dout = 8'h00;
  logic        in_sof = 1'b0, in_eof = 1'b0, in_empty = 1'b1;
  logic        in_rd_en;
  logic [7:0]  out_dout;
  logic        out_sof, out_eof, out_wr_en;
  logic        out_full = 1'b0;
  logic [15:0] drop_count;

  udp_builder dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_sof(in_sof), .in_eof(in_eof),
    .in_empty(in_empty), .in_rd_en(in_rd_en), .out_dout(out_dout), .out_sof(out_sof),
    .out_eof(out_eof), .out_wr_en(out_wr_en), .out_full(out_full), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  logic [9:0] in_q[$];
  logic [9:0] exp_q[$];
  int full_pct = 0, gap_pct = 0;
  bit pop_pend = 1'b0;
  int cyc = 0, eof_cyc = 0, wr_seen = 0;

  bit         m_active = 1'b0, m_dropping = 1'b0;
  logic [7:0] m_buf[$];
  logic [15:0] m_ip_id = 16'h0000;
  int         m_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fold(input int s_in);
    int s;
    s = s_in;
    while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic logic [15:0] ew(input int i);
    return {exp_q[i][7:0], exp_q[i+1][7:0]};
  endfunction

  // Builds the complete expected frame from the buffered payload.
  task automatic emit();
    logic [7:0]  fr[$];
    logic [15:0] ulen, tlen, ipc, udc;
    logic [15:0] words[$];
    int n, s;
    n    = m_buf.size();
    ulen = 16'(n + 8);
    tlen = 16'(n + 28);
    s = 0;
    for (int i = 0; i < n; i++) s += (i % 2 == 0) ? int'(m_buf[i]) * 256 : int'(m_buf[i]);
    s += 'hC0A8 + 'h0001 + 'hC0A8 + 'h0002 + 'h0011 + 2 * int'(ulen) + 'h1234 + 'h5678;
    udc = ~fold(s);
    if (udc == 16'h0000) udc = 16'hFFFF;
    ipc = ~fold('h4500 + int'(tlen) + int'(m_ip_id) + 'h4000 + 'h4011 +
                'hC0A8 + 'h0001 + 'hC0A8 + 'h0002);
    words = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'h0800,
              16'h4500, tlen, m_ip_id, 16'h4000, 16'h4011, ipc, 16'hC0A8, 16'h0001,
              16'hC0A8, 16'h0002, 16'h1234, 16'h5678, ulen, udc};
    foreach (words[i]) begin
      fr.push_back(words[i][15:8]);
      fr.push_back(words[i][7:0]);
    end
    foreach (m_buf[i]) fr.push_back(m_buf[i]);
    foreach (fr[i]) exp_q.push_back({(i == 0), (i == fr.size() - 1), fr[i]});
    m_ip_id++;
  endtask

  task automatic model_item(input logic [9:0] it);
    logic s, e;
    s = it[9];
    e = it[8];
    if (m_dropping) begin
      if (e) m_dropping = 1'b0;
      return;
    end
    if (s) begin
      m_buf.delete();
      m_buf.push_back(it[7:0]);
      m_active = 1'b1;
    end else if (!m_active) begin
      return;
    end else if (m_buf.size() == MAXP) begin
      if (m_drop < 65535) m_drop++;
      m_active   = 1'b0;
      m_dropping = !e;
      return;
    end else begin
      m_buf.push_back(it[7:0]);
    end
    if (e) begin
      emit();
      m_active = 1'b0;
    end
  endtask

  task automatic send(input logic [9:0] it);
    in_q.push_back(it);
    model_item(it);
  endtask

  task automatic send_t1();
    send({2'b10, 8'h41});
    send({2'b00, 8'h42});
    send({2'b00, 8'h43});
    send({2'b01, 8'h44});
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && t < 20000) begin
      @(negedge clock);
      t++;
    end
    repeat (4) @(negedge clock);
    n_cmp++;
    if (t >= 20000) begin
      n_err++;
      $display("FAIL drain_%s: timeout, %0d bytes still expected", name, exp_q.size());
    end
  endtask

  // FWFT input FIFO, output FIFO backpressure, and the per-write compare.
  initial forever begin
    logic [9:0] e;
    @(negedge clock);
    cyc++;
    if (pop_pend && in_q.size() != 0) void'(in_q.pop_front());
    pop_pend = 1'b0;
    if (in_q.size() == 0 || $urandom_range(99) < 32'(gap_pct)) begin
      in_empty = 1'b1;
      {in_sof, in_eof, in_dout} = 10'($urandom);
    end else begin
      in_empty = 1'b0;
      {in_sof, in_eof, in_dout} = in_q[0];
    end
    out_full = ($urandom_range(99) < 32'(full_pct));
    #1;
    if (in_rd_en) begin
      check("rd_while_empty", {31'd0, in_empty}, 32'd0);
      pop_pend = 1'b1;
      if (in_eof) eof_cyc = cyc;
    end
    if (out_wr_en) begin
      wr_seen++;
      check("wr_while_full", {31'd0, out_full}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got byte %h sof %b eof %b, required no write",
                 out_dout, out_sof, out_eof);
      end else begin
        e = exp_q.pop_front();
        check("out_byte", {22'd0, out_sof, out_eof, out_dout}, {22'd0, e});
      end
      if (out_sof && full_pct == 0) check("latency", 32'(cyc - eof_cyc), 32'd3);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, target, t;
    repeat (3) @(negedge clock);
    #2;
    check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
    check("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
    check("rst_dout", {24'd0, out_dout}, 32'd0);
    check("rst_drop", {16'd0, drop_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // T1
    send_t1();
    check("t1_size", exp_q.size(), 46);
    check("t1_tot_len", ew(16), 16'h0020);
    check("t1_ip_csum", ew(24), 16'hB979);
    check("t1_udp_len", ew(38), 16'h000C);
    check("t1_udp_csum", ew(40), 16'h914F);
    check("t1_last", exp_q[45], {2'b01, 8'h44});
    drain("t1");

    // T2: single byte, odd pad
    send({2'b11, 8'h00});
    check("t2_size", exp_q.size(), 43);
    check("t2_tot_len", ew(16), 16'h001D);
    check("t2_udp_len", ew(38), 16'h0009);
    check("t2_sof_eof", {exp_q[0][9:8], exp_q[42][9:8]}, 4'b1001);
    drain("t2");

    // T3: oversize frame (eof on the overflowing byte) then a 4-byte frame
    reset = 1'b0;
    m_ip_id = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < MAXP + 1; i++) send({(i == 0), (i == MAXP), 8'($urandom)});
    send({2'b10, 8'hA0});
    send({2'b00, 8'hA1});
    send({2'b00, 8'hA2});
    send({2'b01, 8'hA3});
    check("t3_size", exp_q.size(), 46);
    check("t3_ip_id", ew(18), 16'h0000);
    check("t3_model_drop", m_drop, 1);
    drain("t3");
    check("t3_drop", {16'd0, drop_count}, 32'(m_drop));

    // Full-length frame accepted; longer frame with late eof goes through DROP
    for (int i = 0; i < MAXP; i++) send({(i == 0), (i == MAXP - 1), 8'($urandom)});
    drain("maxlen");
    for (int i = 0; i < MAXP + 8; i++) send({(i == 0), (i == MAXP + 7), 8'($urandom)});
    send({2'b11, 8'h5A});
    drain("drop2");
    check("drop2_count", {16'd0, drop_count}, 32'(m_drop));

    // T5: restart on mid-frame sof
    send({2'b10, 8'h01});
    send({2'b00, 8'h02});
    send({2'b10, 8'h03});
    send({2'b00, 8'h04});
    send({2'b01, 8'h05});
    check("t5_size", exp_q.size(), 45);
    check("t5_udp_len", ew(38), 16'h000B);
    drain("t5");

    // T4: backpressure and input gaps during T1
    full_pct = 40;
    gap_pct  = 30;
    send_t1();
    drain("t4");

    // Random frames with junk, restarts and backpressure
    for (int f = 0; f < 25; f++) begin
      full_pct = $urandom_range(0, 50);
      gap_pct  = $urandom_range(0, 40);
      if ($urandom_range(3) == 0) send({2'b00, 8'($urandom)});
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++)
        send({((i == 0) || ($urandom_range(19) == 0)), (i == n - 1), 8'($urandom)});
      drain("rand");
    end
    check("rand_drop", {16'd0, drop_count}, 32'(m_drop));

    // T6: reset mid-HEADER
    full_pct = 0;
    gap_pct  = 0;
    send_t1();
    target = wr_seen + 10;
    t = 0;
    while (wr_seen < target && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("t6_reach_header", {31'd0, (t >= 500)}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    in_q.delete();
    m_buf.delete();
    m_active   = 1'b0;
    m_dropping = 1'b0;
    m_ip_id    = 0;
    m_drop     = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #2;
    check("t6_drop_rst", {16'd0, drop_count}, 32'd0);
    repeat (5) @(negedge clock);
    send_t1();
    check("t6_ip_id", ew(18), 16'h0000);
    check("t6_ip_csum", ew(24), 16'hB979);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
